mpu_bus_master: RTL and testbench
=================================

MPU_BUS_MASTER -- requirements
Module: mpu_bus_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, MPU address bus width.
REQ-002 Parameter DATA_WIDTH, default 16, MPU data bus width.
REQ-003 Parameter WAIT_CYCLES, default 2, strobe-low duration in clocks; legal range 2..15.
REQ-004 Ports (clock and reset first):
  clk  in  1  system clock.
  reset  in  1  synchronous active-high reset.
  cmd_valid  in  1  command offered.
  cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at rising edge.
  cmd_wr  in  1  1 = write, 0 = read.
  cmd_be  in  2  byte enables, active high.
  cmd_addr  in  ADDR_WIDTH  target address.
  cmd_wdata  in  DATA_WIDTH  write data.
  rsp_valid  out  1  response available.
  rsp_ready  in  1  response consumed when rsp_valid&rsp_ready at rising edge.
  rsp_rdata  out  DATA_WIDTH  read data (0 for writes).
  _mpu_en  out  1  bus enable, active low.
  _mpu_rd  out  1  read strobe, active low.
  _mpu_wr  out  1  write strobe, active low.
  _mpu_be  out  2  byte enables, active low.
  mpu_addr  out  ADDR_WIDTH  address bus.
  mpu_data_out  out  DATA_WIDTH  data driven to the device.
  mpu_data_in  in  DATA_WIDTH  data returned by the device.
REQ-005 Clocking and reset are fixed: one clock (clk); reset is synchronous and active-high (reset).

Function
REQ-006 The FSM SHALL have states IDLE, SETUP, STROBE, HOLD, RESP; all bus outputs SHALL be registered.
REQ-007 cmd_ready SHALL be 1 only in IDLE; acceptance SHALL latch cmd_wr/cmd_be/cmd_addr/cmd_wdata and enter SETUP.
REQ-008 SETUP (1 cycle): _mpu_en=0, mpu_addr and _mpu_be=~be valid, both strobes 1.
REQ-009 STROBE (exactly WAIT_CYCLES cycles, 4-bit down-counter): _mpu_rd=0 for reads or _mpu_wr=0 for writes; address/be/en held stable.
REQ-010 Read data SHALL be sampled from mpu_data_in on the edge leaving STROBE.
REQ-011 HOLD (1 cycle): strobes 1, _mpu_en=0, address/be/data held; then RESP.
REQ-012 RESP: rsp_valid=1, rsp_rdata stable; on rsp_ready go to IDLE; held indefinitely while rsp_ready=0 (cmd_ready stays 0).
REQ-013 rsp_valid SHALL first assert WAIT_CYCLES+2 edges after the acceptance edge.
REQ-014 mpu_data_out SHALL equal latched wdata in SETUP/STROBE/HOLD of a write; 0 otherwise.
REQ-015 In IDLE and RESP: _mpu_en=_mpu_rd=_mpu_wr=1, _mpu_be=2'b11, mpu_addr=0.
REQ-016 A command with cmd_be=0 SHALL still run a full cycle with _mpu_be=2'b11.
REQ-017 _mpu_rd and _mpu_wr SHALL never be 0 simultaneously.
REQ-018 Minimum spacing between two bus cycles SHALL be one IDLE cycle (back-to-back cmd_valid allowed).

Reset
REQ-019 Reset SHALL force IDLE at the next edge from any state, abort any cycle, and drop the response; outputs: cmd_ready=1, rsp_valid=0, rsp_rdata=0, bus outputs per REQ-015, mpu_data_out=0.

Configuration
REQ-020 Macro MPU_BUS_MASTER_POSTED_WR_EN: defined -> writes skip RESP (HOLD -> IDLE, no response); undefined -> every command, read or write, produces exactly one response.

Structure
REQ-021 Package mpu_bus_pkg SHALL hold the state enum, default ADDR/DATA widths, WAIT_CYCLES default and range limits.
REQ-022 Sub-module mpu_wait_counter (loadable 4-bit down-counter with done flag) SHALL time the STROBE phase.

Verification
REQ-023 Read addr 0x1234, be=2'b11, device returns 0xBEEF: _mpu_rd low exactly 2 cycles, rsp_rdata=0xBEEF after 4 edges.
REQ-024 Write addr 0x0040 data 0xA55A be=2'b01: _mpu_wr low 2 cycles, _mpu_be=2'b10, mpu_data_out=0xA55A; response per macro setting.
REQ-025 rsp_ready held 0 for 10 cycles after a read: rsp_valid stays 1, cmd_ready 0, bus idle; second command accepted only after consume.
REQ-026 reset asserted during STROBE: next edge all strobes/en=1, rsp_valid=0, cmd_ready=1; no response ever emitted.
REQ-027 WAIT_CYCLES=5, two back-to-back reads: each strobe low 5 cycles, one IDLE cycle between bus cycles, rd/wr never both low.

Source files
------------

// File: rtl/mpu_bus_pkg.sv
// Shared types and limits for the MPU bus master.
// Used by mpu_bus_master and mpu_wait_counter.
package mpu_bus_pkg;

    localparam int MPU_ADDR_WIDTH  = 16;
    localparam int MPU_DATA_WIDTH  = 16;
    localparam int MPU_WAIT_CYCLES = 2;
    localparam int MPU_WAIT_MIN    = 2;
    localparam int MPU_WAIT_MAX    = 15;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        RESP   = 3'd4
    } mpu_state_t;

    // Counter load value for a strobe of 'cycles' clocks.
    // Out-of-range values are clamped into the legal strobe range.
    function automatic logic [3:0] wait_load(input int cycles);
        int c;
        c = cycles;
        if (c < MPU_WAIT_MIN) c = MPU_WAIT_MIN;
        if (c > MPU_WAIT_MAX) c = MPU_WAIT_MAX;
        return 4'(c - 1);
    endfunction

endpackage

// File: rtl/mpu_wait_counter.sv
// Loadable 4-bit down-counter timing the strobe phase.
// done is high whenever the count has reached zero.
module mpu_wait_counter
    import mpu_bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       done
);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign done = (count == 4'd0);

endmodule

// File: rtl/mpu_bus_master.sv
// Command/response to asynchronous MPU bus master with registered bus outputs.
// Optional macro MPU_BUS_MASTER_POSTED_WR_EN: writes complete without a response.
module mpu_bus_master
    import mpu_bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = MPU_ADDR_WIDTH,
    parameter int DATA_WIDTH  = MPU_DATA_WIDTH,
    parameter int WAIT_CYCLES = MPU_WAIT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [1:0]            cmd_be,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  _mpu_en,
    output logic                  _mpu_rd,
    output logic                  _mpu_wr,
    output logic [1:0]            _mpu_be,
    output logic [ADDR_WIDTH-1:0] mpu_addr,
    output logic [DATA_WIDTH-1:0] mpu_data_out,
    input  logic [DATA_WIDTH-1:0] mpu_data_in
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and ready is a registered flag that is 1 only in IDLE.

    mpu_state_t            state, nxt;
    logic                  lat_wr;
    logic [1:0]            lat_be;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  accept, cnt_load, cnt_done, bus_active;
    logic                  sel_wr;
    logic [1:0]            sel_be;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    mpu_wait_counter u_wait (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (wait_load(WAIT_CYCLES)),
        .dec      (state == STROBE),
        .done     (cnt_done)
    );

    assign accept = (state == IDLE) && cmd_valid;

    always_comb begin
        nxt      = state;
        cnt_load = 1'b0;
        case (state)
            IDLE:    if (cmd_valid) nxt = SETUP;
            SETUP: begin
                nxt      = STROBE;
                cnt_load = 1'b1;
            end
            STROBE:  if (cnt_done) nxt = HOLD;
            HOLD: begin
`ifdef MPU_BUS_MASTER_POSTED_WR_EN
                nxt = lat_wr ? IDLE : RESP;
`else
                nxt = RESP;
`endif
            end
            RESP:    if (rsp_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Bus outputs are registered from the next state, so on the acceptance edge
    // the command fields come straight from the inputs rather than the latches.
    always_comb begin
        sel_wr     = accept ? cmd_wr    : lat_wr;
        sel_be     = accept ? cmd_be    : lat_be;
        sel_addr   = accept ? cmd_addr  : lat_addr;
        sel_wdata  = accept ? cmd_wdata : lat_wdata;
        bus_active = (nxt == SETUP) || (nxt == STROBE) || (nxt == HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            lat_wr       <= 1'b0;
            lat_be       <= 2'b00;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            cmd_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            _mpu_en      <= 1'b1;
            _mpu_rd      <= 1'b1;
            _mpu_wr      <= 1'b1;
            _mpu_be      <= 2'b11;
            mpu_addr     <= '0;
            mpu_data_out <= '0;
        end else begin
            state     <= nxt;
            cmd_ready <= (nxt == IDLE);
            rsp_valid <= (nxt == RESP);
            if (accept) begin
                lat_wr    <= cmd_wr;
                lat_be    <= cmd_be;
                lat_addr  <= cmd_addr;
                lat_wdata <= cmd_wdata;
                rsp_rdata <= '0;
            end else if ((state == STROBE) && cnt_done && !lat_wr) begin
                rsp_rdata <= mpu_data_in;
            end
            _mpu_en      <= !bus_active;
            _mpu_rd      <= !((nxt == STROBE) && !sel_wr);
            _mpu_wr      <= !((nxt == STROBE) && sel_wr);
            _mpu_be      <= bus_active ? ~sel_be : 2'b11;
            mpu_addr     <= bus_active ? sel_addr : '0;
            mpu_data_out <= (bus_active && sel_wr) ? sel_wdata : '0;
        end
    end

endmodule

// File: tb/tb_mpu_bus_master.sv
// Directed self-checking bench for mpu_bus_master: WAIT_CYCLES=2 instance for
// single-command scenarios, WAIT_CYCLES=5 instance for back-to-back reads.
module tb_mpu_bus_master;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];

    // Instance A (WAIT_CYCLES = 2)
    logic        cmd_valid = 1'b0, cmd_wr = 1'b0, rsp_ready = 1'b0;
    logic [1:0]  cmd_be = 2'b00;
    logic [15:0] cmd_addr = '0, cmd_wdata = '0, dev_data = '0;
    logic        cmd_ready, rsp_valid, en_n, rd_n, wr_n;
    logic [1:0]  be_n;
    logic [15:0] rsp_rdata, mpu_addr, data_out, data_in;
    assign data_in = !rd_n ? dev_data : 16'hDEAD;

    mpu_bus_master #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_be(cmd_be),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        ._mpu_en(en_n), ._mpu_rd(rd_n), ._mpu_wr(wr_n), ._mpu_be(be_n),
        .mpu_addr(mpu_addr), .mpu_data_out(data_out), .mpu_data_in(data_in)
    );

    // Instance B (WAIT_CYCLES = 5); device returns the byte-swapped address
    logic        cmd_valid_b = 1'b0, cmd_wr_b = 1'b0, rsp_ready_b = 1'b0;
    logic [1:0]  cmd_be_b = 2'b11;
    logic [15:0] cmd_addr_b = '0, cmd_wdata_b = '0;
    logic        cmd_ready_b, rsp_valid_b, en_n_b, rd_n_b, wr_n_b;
    logic [1:0]  be_n_b;
    logic [15:0] rsp_rdata_b, mpu_addr_b, data_out_b, data_in_b;
    assign data_in_b = !rd_n_b ? {mpu_addr_b[7:0], mpu_addr_b[15:8]} : 16'h0000;

    mpu_bus_master #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .WAIT_CYCLES(5)) dut_b (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_wr(cmd_wr_b), .cmd_be(cmd_be_b),
        .cmd_addr(cmd_addr_b), .cmd_wdata(cmd_wdata_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_rdata(rsp_rdata_b),
        ._mpu_en(en_n_b), ._mpu_rd(rd_n_b), ._mpu_wr(wr_n_b), ._mpu_be(be_n_b),
        .mpu_addr(mpu_addr_b), .mpu_data_out(data_out_b), .mpu_data_in(data_in_b)
    );

    // Driver: offer one command to instance A and let it be accepted.
    task automatic issue(input logic wr, input logic [1:0] be, input logic [15:0] addr,
                         input logic [15:0] wdata);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_be = be; cmd_addr = addr; cmd_wdata = wdata;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL issue_ready: cmd_ready=%b expected 1", cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Driver: step instance A from SETUP until a response or return to IDLE.
    task automatic run_bus(input logic [15:0] exp_addr, input logic [1:0] exp_be_n,
                           input logic [15:0] exp_dout, output int edges, output int rd_low,
                           output int wr_low, output int both_low, output int en_low,
                           output int field_bad);
        edges = 0; rd_low = 0; wr_low = 0; both_low = 0; en_low = 0; field_bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid || cmd_ready) break;
            if (!en_n) begin
                en_low++;
                if (mpu_addr !== exp_addr || be_n !== exp_be_n || data_out !== exp_dout)
                    field_bad++;
            end
            if (!rd_n) rd_low++;
            if (!wr_n) wr_low++;
            if (!rd_n && !wr_n) both_low++;
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic consume;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL consume: rsp_valid=%b cmd_ready=%b expected 0/1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        n_cmp++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 16'h0) begin
            n_bad++; $display("FAIL reset_hs: ready=%b valid=%b rdata=%h expected 1/0/0000", cmd_ready, rsp_valid, rsp_rdata);
        end
        n_cmp++;
        if ({en_n, rd_n, wr_n, be_n} !== 5'b11111 || mpu_addr !== 16'h0 || data_out !== 16'h0) begin
            n_bad++; $display("FAIL reset_bus: en/rd/wr/be=%b addr=%h dout=%h expected 11111/0000/0000", {en_n, rd_n, wr_n, be_n}, mpu_addr, data_out);
        end
    endtask

    task automatic test_read;
        int e, rl, wl, bl, el, fb;
        dev_data = 16'hBEEF;
        issue(1'b0, 2'b11, 16'h1234, 16'h0000);
        run_bus(16'h1234, 2'b00, 16'h0000, e, rl, wl, bl, el, fb);
        n_cmp++;
        if (e !== 4) begin n_bad++; $display("FAIL rd_latency: edges=%0d expected 4", e); end
        n_cmp++;
        if (rl !== 2 || wl !== 0 || bl !== 0) begin
            n_bad++; $display("FAIL rd_strobe: rd_low=%0d wr_low=%0d both=%0d expected 2/0/0", rl, wl, bl);
        end
        n_cmp++;
        if (el !== 4 || fb !== 0) begin
            n_bad++; $display("FAIL rd_fields: en_low=%0d field_bad=%0d expected 4/0", el, fb);
        end
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hBEEF) begin
            n_bad++; $display("FAIL rd_data: valid=%b rdata=%h expected 1/beef", rsp_valid, rsp_rdata);
        end
        n_cmp++;
        if ({en_n, rd_n, wr_n, be_n} !== 5'b11111 || mpu_addr !== 16'h0 || cmd_ready !== 1'b0) begin
            n_bad++; $display("FAIL resp_idle: en/rd/wr/be=%b addr=%h ready=%b expected 11111/0000/0", {en_n, rd_n, wr_n, be_n}, mpu_addr, cmd_ready);
        end
        consume();
    endtask

    task automatic test_write;
        int e, rl, wl, bl, el, fb;
        issue(1'b1, 2'b01, 16'h0040, 16'hA55A);
        run_bus(16'h0040, 2'b10, 16'hA55A, e, rl, wl, bl, el, fb);
        n_cmp++;
        if (wl !== 2 || rl !== 0 || bl !== 0) begin
            n_bad++; $display("FAIL wr_strobe: wr_low=%0d rd_low=%0d both=%0d expected 2/0/0", wl, rl, bl);
        end
        n_cmp++;
        if (el !== 4 || fb !== 0) begin
            n_bad++; $display("FAIL wr_fields: en_low=%0d field_bad=%0d expected 4/0", el, fb);
        end
        n_cmp++;
        if (e !== 4) begin n_bad++; $display("FAIL wr_latency: edges=%0d expected 4", e); end
`ifdef MPU_BUS_MASTER_POSTED_WR_EN
        n_cmp++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL wr_posted: valid=%b ready=%b expected 0/1", rsp_valid, cmd_ready);
        end
`else
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h0000) begin
            n_bad++; $display("FAIL wr_resp: valid=%b rdata=%h expected 1/0000", rsp_valid, rsp_rdata);
        end
        consume();
`endif
        n_cmp++;
        if (data_out !== 16'h0) begin n_bad++; $display("FAIL wr_dout_idle: dout=%h expected 0000", data_out); end
    endtask

    task automatic test_be_zero;
        int e, rl, wl, bl, el, fb;
        dev_data = 16'h0F0F;
        issue(1'b0, 2'b00, 16'h0777, 16'h0000);
        run_bus(16'h0777, 2'b11, 16'h0000, e, rl, wl, bl, el, fb);
        n_cmp++;
        if (e !== 4 || rl !== 2 || el !== 4 || fb !== 0) begin
            n_bad++; $display("FAIL be_zero: edges=%0d rd_low=%0d en_low=%0d field_bad=%0d expected 4/2/4/0", e, rl, el, fb);
        end
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h0F0F) begin
            n_bad++; $display("FAIL be_zero_data: valid=%b rdata=%h expected 1/0f0f", rsp_valid, rsp_rdata);
        end
        consume();
    endtask

    task automatic test_stall;
        int e, rl, wl, bl, el, fb, bad;
        dev_data = 16'h1111;
        issue(1'b0, 2'b11, 16'h0002, 16'h0000);
        run_bus(16'h0002, 2'b00, 16'h0000, e, rl, wl, bl, el, fb);
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_be = 2'b11; cmd_addr = 16'h0300;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || en_n !== 1'b1 || rsp_rdata !== 16'h1111)
                bad++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (bad !== 0) begin n_bad++; $display("FAIL stall_hold: bad_cycles=%0d expected 0", bad); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || en_n !== 1'b1) begin
            n_bad++; $display("FAIL stall_release: valid=%b ready=%b en=%b expected 0/1/1", rsp_valid, cmd_ready, en_n);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n_cmp++;
        if (en_n !== 1'b0 || mpu_addr !== 16'h0300) begin
            n_bad++; $display("FAIL stall_second: en=%b addr=%h expected 0/0300", en_n, mpu_addr);
        end
        run_bus(16'h0300, 2'b00, 16'h0000, e, rl, wl, bl, el, fb);
        n_cmp++;
        if (rl !== 2 || rsp_valid !== 1'b1) begin
            n_bad++; $display("FAIL stall_second_rd: rd_low=%0d valid=%b expected 2/1", rl, rsp_valid);
        end
        consume();
    endtask

    task automatic test_reset_mid;
        int seen;
        issue(1'b0, 2'b11, 16'h0055, 16'h0000);
        @(posedge clk); #1;
        n_cmp++;
        if (rd_n !== 1'b0) begin n_bad++; $display("FAIL abort_in_strobe: rd=%b expected 0", rd_n); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++;
        if ({en_n, rd_n, wr_n, be_n} !== 5'b11111 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL abort: en/rd/wr/be=%b valid=%b ready=%b expected 11111/0/1", {en_n, rd_n, wr_n, be_n}, rsp_valid, cmd_ready);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0 || cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL abort_no_resp: rsp_cycles=%0d ready=%b expected 0/1", seen, cmd_ready);
        end
    endtask

    task automatic test_back_to_back;
        int n_acc, n_rsp, bus_cycles, idle_between, run, n_runs, bad_runs, both;
        logic acc, take, prev_en;
        logic [15:0] exp;
        n_acc = 0; n_rsp = 0; bus_cycles = 0; idle_between = 0;
        run = 0; n_runs = 0; bad_runs = 0; both = 0; prev_en = 1'b1;
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0002);
        cmd_valid_b = 1'b1; cmd_wr_b = 1'b0; cmd_be_b = 2'b11; cmd_addr_b = 16'h0100;
        rsp_ready_b = 1'b1;
        for (int i = 0; i < 80 && n_rsp < 2; i++) begin
            acc  = cmd_valid_b && cmd_ready_b;
            take = rsp_valid_b && rsp_ready_b;
            if (take) begin
                n_rsp++;
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hXXXX;
                n_cmp++;
                if (rsp_rdata_b !== exp) begin
                    n_bad++; $display("FAIL b2b_data: rdata=%h expected %h", rsp_rdata_b, exp);
                end
            end
            @(posedge clk); #1;
            if (acc) begin
                n_acc++;
                if (n_acc == 1) cmd_addr_b = 16'h0200;
                else cmd_valid_b = 1'b0;
            end
            if (prev_en && !en_n_b) bus_cycles++;
            if (cmd_ready_b && bus_cycles == 1) idle_between++;
            if (!rd_n_b) run++;
            else if (run != 0) begin
                n_runs++;
                if (run != 5) bad_runs++;
                run = 0;
            end
            if (!rd_n_b && !wr_n_b) both++;
            prev_en = en_n_b;
        end
        cmd_valid_b = 1'b0;
        rsp_ready_b = 1'b0;
        n_cmp++;
        if (n_acc !== 2 || n_rsp !== 2 || exp_q.size() !== 0) begin
            n_bad++; $display("FAIL b2b_count: acc=%0d rsp=%0d left=%0d expected 2/2/0", n_acc, n_rsp, exp_q.size());
        end
        n_cmp++;
        if (n_runs !== 2 || bad_runs !== 0) begin
            n_bad++; $display("FAIL b2b_strobe: runs=%0d bad_runs=%0d expected 2/0", n_runs, bad_runs);
        end
        n_cmp++;
        if (idle_between !== 1) begin
            n_bad++; $display("FAIL b2b_gap: idle_cycles=%0d expected 1", idle_between);
        end
        n_cmp++;
        if (both !== 0) begin n_bad++; $display("FAIL b2b_both_low: cycles=%0d expected 0", both); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_be_zero();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
